four_phase_sender: RTL and testbench

Synchronous initiator for a four-phase (return-to-zero) bundled-data req/ack channel. It accepts words from clocked logic over a valid/ready interface and presents each word on `data_out`. It then sequences `req` through the full four-phase cycle, sampling the asynchronous `ack` through a synchronizer. It is the active end of every channel our four-phase checker monitors, and it flags timeouts and protocol violations.

---
 rtl/four_phase_sender.sv | 152 +++++++++++++++
 tb/tb_four_phase_sender.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/four_phase_sender.sv
// four_phase_sender: valid/ready to four-phase bundled-data req/ack initiator.
// Synchronises the async ack, sequences req, and flags timeouts and protocol violations.
module four_phase_sender #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned SETUP_CYCLES   = 1,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  req,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  ack,
  output logic                  xfer_done,
  output logic [15:0]           xfer_count,
  output logic                  timeout_err,
  output logic                  proto_err
);

  localparam int unsigned T_MAX = (TIMEOUT_CYCLES > SYNC_STAGES) ? TIMEOUT_CYCLES : SYNC_STAGES;
  localparam int unsigned TW    = $clog2(T_MAX + 1);
  localparam int unsigned SW    = $clog2(SETUP_CYCLES + 1);

  typedef enum logic [2:0] {
    DRAIN   = 3'd0,
    IDLE    = 3'd1,
    SETUP   = 3'd2,
    WAIT_HI = 3'd3,
    WAIT_LO = 3'd4
  } state_t;

  state_t                 state_q, state_n;
  logic                   req_q, req_n;
  logic [DATA_WIDTH-1:0]  data_q, data_n;
  logic                   done_q, done_n;
  logic [15:0]            xcnt_q, xcnt_n;
  logic                   terr_q, terr_n;
  logic                   perr_q, perr_n;
  logic [SW-1:0]          scnt_q, scnt_n;
  logic [TW-1:0]          tcnt_q, tcnt_n;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ack_s;
  logic                   waiting;
  logic                   entering_wait;

  // ack synchroniser; only its last stage is ever looked at
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], ack};
  end

  assign ack_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DRAIN;
      req_q   <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      xcnt_q  <= '0;
      terr_q  <= 1'b0;
      perr_q  <= 1'b0;
      scnt_q  <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_n;
      req_q   <= req_n;
      data_q  <= data_n;
      done_q  <= done_n;
      xcnt_q  <= xcnt_n;
      terr_q  <= terr_n;
      perr_q  <= perr_n;
      scnt_q  <= scnt_n;
      tcnt_q  <= tcnt_n;
    end
  end

  assign waiting       = (state_q == DRAIN) || (state_q == WAIT_HI) || (state_q == WAIT_LO);
  assign entering_wait = (state_n != state_q) &&
                         ((state_n == DRAIN) || (state_n == WAIT_HI) || (state_n == WAIT_LO));

  always_comb begin
    state_n = state_q;
    req_n   = req_q;
    data_n  = data_q;
    done_n  = 1'b0;
    xcnt_n  = xcnt_q;
    terr_n  = terr_q;
    perr_n  = perr_q;
    scnt_n  = scnt_q;
    tcnt_n  = tcnt_q;

    case (state_q)
      DRAIN: begin
        if ((tcnt_q >= TW'(SYNC_STAGES)) && !ack_s) state_n = IDLE;
      end
      IDLE: begin
        if (ack_s) perr_n = 1'b1;
        if (in_valid) begin
          data_n  = in_data;
          scnt_n  = SW'(SETUP_CYCLES);
          state_n = SETUP;
        end
      end
      SETUP: begin
        // a stray ack before req rise parks the launch until ack_s drops
        if (ack_s) begin
          perr_n = 1'b1;
          scnt_n = '0;
        end else if (scnt_q <= SW'(1)) begin
          scnt_n  = '0;
          req_n   = 1'b1;
          state_n = WAIT_HI;
        end else begin
          scnt_n = scnt_q - SW'(1);
        end
      end
      WAIT_HI: begin
        if (ack_s) begin
          req_n   = 1'b0;
          done_n  = 1'b1;
          xcnt_n  = xcnt_q + 16'd1;
          state_n = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (!ack_s) state_n = IDLE;
      end
      default: state_n = DRAIN;
    endcase

    // saturating wait-time counter; the FSM keeps waiting after a timeout
    if (entering_wait) begin
      tcnt_n = '0;
    end else if (waiting) begin
      if (tcnt_q != '1) tcnt_n = tcnt_q + TW'(1);
      if ((TIMEOUT_CYCLES != 0) && (tcnt_n == TW'(TIMEOUT_CYCLES))) terr_n = 1'b1;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign req         = req_q;
  assign data_out    = data_q;
  assign xfer_done   = done_q;
  assign xfer_count  = xcnt_q;
  assign timeout_err = terr_q;
  assign proto_err   = perr_q;

endmodule

// File: tb/tb_four_phase_sender.sv
// Directed testbench for four_phase_sender: drain, single transfer, streaming,
// count wrap, protocol violation, timeout and mid-transfer reset.
module tb_four_phase_sender;

  localparam int unsigned DW = 8;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          req;
  logic [DW-1:0] data_out;
  logic          ack;
  logic          xfer_done;
  logic [15:0]   xfer_count;
  logic          timeout_err;
  logic          proto_err;

  int tests = 0;
  int fails = 0;

  four_phase_sender #(
    .DATA_WIDTH    (DW),
    .SYNC_STAGES   (2),
    .SETUP_CYCLES  (1),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .req        (req),
    .data_out   (data_out),
    .ack        (ack),
    .xfer_done  (xfer_done),
    .xfer_count (xfer_count),
    .timeout_err(timeout_err),
    .proto_err  (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // inputs change and outputs are sampled on the falling edge
  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bound_fail(input string tag);
    tests++;
    fails++;
    $error("FAIL %s observed=no_event expected=event_within_bound", tag);
  endtask

  task automatic wait_req(input logic lvl, input string tag);
    int n = 0;
    while (req !== lvl && n < 64) begin
      step();
      n++;
    end
    if (req !== lvl) bound_fail(tag);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (in_ready !== 1'b1 && n < 64) begin
      step();
      n++;
    end
    if (in_ready !== 1'b1) bound_fail(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    wait_ready("reset_drain_wait");
  endtask

  // one word with a responder that acks dh cycles after req rise, drops dl after req fall
  task automatic xfer(input logic [DW-1:0] d, input int dh, input int dl);
    wait_ready("xfer_ready_wait");
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
    wait_req(1'b1, "xfer_req_rise_wait");
    check("xfer_data", 32'(data_out), 32'(d));
    repeat (dh) step();
    ack = 1'b1;
    wait_req(1'b0, "xfer_req_fall_wait");
    check("xfer_done_pulse", 32'(xfer_done), 32'd1);
    repeat (dl) step();
    ack = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    ack      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;

    // reset values, with ack held high through reset
    repeat (3) step();
    check("rst_req",         32'(req),         32'd0);
    check("rst_data_out",    32'(data_out),    32'd0);
    check("rst_xfer_done",   32'(xfer_done),   32'd0);
    check("rst_xfer_count",  32'(xfer_count),  32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    check("rst_proto_err",   32'(proto_err),   32'd0);
    check("rst_in_ready",    32'(in_ready),    32'd0);

    // drain: ack stays high 10 cycles past reset release
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("drain_ready_held", 32'(in_ready), 32'd0);
    end
    ack = 1'b0;
    step();
    check("drain_ready_rel1", 32'(in_ready), 32'd0);
    step();
    check("drain_ready_rel2", 32'(in_ready), 32'd0);
    step();
    check("drain_ready_rel3", 32'(in_ready), 32'd1);
    check("drain_proto_err",  32'(proto_err), 32'd0);

    // single transfer 0xA5, responder delay 3 each way
    in_valid = 1'b1;
    in_data  = 8'hA5;
    step();
    in_valid = 1'b0;
    check("single_data_load", 32'(data_out), 32'hA5);
    check("single_req_n",     32'(req),      32'd0);
    check("single_busy",      32'(in_ready), 32'd0);
    step();
    check("single_req_n1",    32'(req),      32'd1);
    step();
    step();
    ack = 1'b1;
    step();
    check("single_req_m",     32'(req),       32'd1);
    check("single_data_m",    32'(data_out),  32'hA5);
    step();
    check("single_req_m1",    32'(req),       32'd1);
    check("single_done_m1",   32'(xfer_done), 32'd0);
    check("single_data_m1",   32'(data_out),  32'hA5);
    step();
    check("single_req_fall",  32'(req),        32'd0);
    check("single_done",      32'(xfer_done),  32'd1);
    check("single_count",     32'(xfer_count), 32'd1);
    step();
    check("single_done_once", 32'(xfer_done),  32'd0);
    step();
    ack = 1'b0;
    step();
    step();
    check("single_lo_busy",   32'(in_ready), 32'd0);
    step();
    check("single_lo_ready",  32'(in_ready), 32'd1);
    check("single_count_end", 32'(xfer_count), 32'd1);

    // streaming: 300 random words, 0..5 cycle responder delays
    do_reset();
    for (int i = 0; i < 300; i++) begin
      xfer(8'($urandom), int'($urandom_range(0, 5)), int'($urandom_range(0, 5)));
    end
    wait_ready("stream_end_wait");
    check("stream_count",       32'(xfer_count),  32'd300);
    check("stream_proto_err",   32'(proto_err),   32'd0);
    check("stream_timeout_err", 32'(timeout_err), 32'd0);

    // transfer counter wrap from 0xFFFF
    force dut.xcnt_q = 16'hFFFF;
    step();
    release dut.xcnt_q;
    step();
    check("wrap_preload", 32'(xfer_count), 32'hFFFF);
    xfer(8'h3C, 1, 1);
    check("wrap_count", 32'(xfer_count), 32'd0);
    wait_ready("wrap_end_wait");

    // protocol violation: 5-cycle ack pulse while idle, word offered meanwhile
    ack = 1'b1;
    step();
    check("proto_err_a0",   32'(proto_err), 32'd0);
    step();
    check("proto_err_a1",   32'(proto_err), 32'd0);
    step();
    check("proto_err_set",  32'(proto_err), 32'd1);
    check("proto_idle",     32'(in_ready),  32'd1);
    in_valid = 1'b1;
    in_data  = 8'h5A;
    step();
    in_valid = 1'b0;
    check("proto_req_a3",   32'(req), 32'd0);
    step();
    ack = 1'b0;
    check("proto_req_a4",   32'(req), 32'd0);
    step();
    check("proto_req_a5",   32'(req), 32'd0);
    step();
    check("proto_req_a6",   32'(req), 32'd0);
    step();
    check("proto_req_rise", 32'(req),       32'd1);
    check("proto_data",     32'(data_out),  32'h5A);
    check("proto_sticky",   32'(proto_err), 32'd1);
    ack = 1'b1;
    wait_req(1'b0, "proto_req_fall_wait");
    ack = 1'b0;
    wait_ready("proto_end_wait");

    // timeout at 16 cycles, then a late ack completes normally
    do_reset();
    in_valid = 1'b1;
    in_data  = 8'h77;
    step();
    in_valid = 1'b0;
    step();
    check("to_req_rise", 32'(req), 32'd1);
    repeat (15) step();
    check("to_before",   32'(timeout_err), 32'd0);
    step();
    check("to_set",      32'(timeout_err), 32'd1);
    check("to_req_held", 32'(req),         32'd1);
    repeat (4) step();
    check("to_still_waiting", 32'(req), 32'd1);
    ack = 1'b1;
    wait_req(1'b0, "to_req_fall_wait");
    check("to_late_done",  32'(xfer_done),  32'd1);
    check("to_late_count", 32'(xfer_count), 32'd1);
    check("to_late_data",  32'(data_out),   32'h77);
    ack = 1'b0;
    wait_ready("to_end_wait");
    check("to_sticky", 32'(timeout_err), 32'd1);

    // reset in WAIT_HI returns every output to its reset value at once
    in_valid = 1'b1;
    in_data  = 8'h99;
    step();
    in_valid = 1'b0;
    wait_req(1'b1, "mid_req_rise_wait");
    step();
    rst = 1'b1;
    step();
    check("mid_req",         32'(req),         32'd0);
    check("mid_data_out",    32'(data_out),    32'd0);
    check("mid_xfer_done",   32'(xfer_done),   32'd0);
    check("mid_xfer_count",  32'(xfer_count),  32'd0);
    check("mid_timeout_err", 32'(timeout_err), 32'd0);
    check("mid_proto_err",   32'(proto_err),   32'd0);
    check("mid_in_ready",    32'(in_ready),    32'd0);
    rst = 1'b0;
    wait_ready("mid_drain_wait");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
